// File: rtl/quad_decoder.sv
// quad_decoder: x4 quadrature decoder with signed position, step pulses, direction and sticky error.
module quad_decoder #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 a,
  input  logic                 b,
  input  logic                 clear,
  output logic [CNT_WIDTH-1:0] position,
  output logic                 up,
  output logic                 dn,
  output logic                 dir,
  output logic                 err
);
  logic [1:0] cur, prev, pi, ci, d;
  logic primed, fwd, rev, bad;
  // Gray-to-binary phase index; forward motion walks the index downward by one.
  always_comb begin
    pi  = {prev[1], ^prev};
    ci  = {cur[1], ^cur};
    d   = pi - ci;
    fwd = primed && d == 2'd1;
    rev = primed && d == 2'd3;
    bad = primed && d == 2'd2;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      cur      <= 2'b00;
      prev     <= 2'b00;
      primed   <= 1'b0;
      position <= '0;
      up       <= 1'b0;
      dn       <= 1'b0;
      dir      <= 1'b1;
      err      <= 1'b0;
    end else begin
      cur      <= {a, b};
      prev     <= primed ? cur : {a, b};
      primed   <= 1'b1;
      up       <= fwd;
      dn       <= rev;
      dir      <= fwd ? 1'b1 : rev ? 1'b0 : dir;
      err      <= !clear && (err || bad);
      position <= clear ? '0 : fwd ? position + CNT_WIDTH'(1) : rev ? position - CNT_WIDTH'(1) : position;
    end
endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: scoreboard bench; expected step pulses are queued at drive time and popped by a monitor.
module tb_quad_decoder;
  logic clock = 1'b0, reset = 1'b0, a = 1'b1, b = 1'b1, clear = 1'b0;
  logic [15:0] position;
  logic up, dn, dir, err;

  quad_decoder #(.CNT_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .a(a), .b(b), .clear(clear),
    .position(position), .up(up), .dn(dn), .dir(dir), .err(err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic        fwd;
    logic [15:0] pos;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int tests = 0, fails = 0;
  logic [1:0] m_prev = 2'b11;
  logic [15:0] m_pos = 16'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] nxt(input logic [1:0] p);
    case (p)
      2'b00:   nxt = 2'b10;
      2'b10:   nxt = 2'b11;
      2'b11:   nxt = 2'b01;
      default: nxt = 2'b00;
    endcase
  endfunction

  exp_t e;
  always @(negedge clock)
    if (reset && (up || dn)) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: got up=%b dn=%b pos=%h expected no pulse at cycle %0d", up, dn, position, cyc);
      end else begin
        e = q.pop_front();
        check("pulse_kind", {30'd0, up, dn}, {30'd0, e.fwd, ~e.fwd});
        check("pulse_pos", {16'd0, position}, {16'd0, e.pos});
        check("pulse_dir", {31'd0, dir}, {31'd0, e.fwd});
        check("pulse_cycle", cyc, e.cyc);
      end
    end

  task automatic step(input logic [1:0] ab, input int hold);
    exp_t x;
    @(negedge clock);
    {a, b} = ab;
    x.cyc = cyc + 2;
    if (ab == nxt(m_prev)) begin
      m_pos = m_pos + 16'd1;
      x.fwd = 1'b1; x.pos = m_pos; q.push_back(x);
    end else if (nxt(ab) == m_prev) begin
      m_pos = m_pos - 16'd1;
      x.fwd = 1'b0; x.pos = m_pos; q.push_back(x);
    end
    m_prev = ab;
    repeat (hold - 1) @(negedge clock);
  endtask

  task automatic settle();
    repeat (3) @(negedge clock);
  endtask

  task automatic do_reset(input logic [1:0] ab);
    @(negedge clock);
    reset = 1'b0;
    {a, b} = ab;
    @(negedge clock);
    reset = 1'b1;
    m_prev = ab;
    m_pos = 16'h0;
  endtask

  initial begin
    exp_t x;
    repeat (3) @(negedge clock);
    check("rst_pos", {16'd0, position}, 32'd0);
    check("rst_dir", {31'd0, dir}, 32'd1);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_updn", {30'd0, up, dn}, 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("prime_pos", {16'd0, position}, 32'd0);
      check("prime_flags", {28'd0, up, dn, dir, err}, 32'b0010);
    end
    do_reset(2'b00);
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 4; k++) step(nxt(m_prev), 5);
    settle();
    check("fwd_pos", {16'd0, position}, 32'd12);
    check("fwd_dir", {31'd0, dir}, 32'd1);
    for (int r = 0; r < 4; r++) begin
      step(2'b01, 5); step(2'b11, 5); step(2'b10, 5); step(2'b00, 5);
    end
    settle();
    check("rev_pos", {16'd0, position}, 32'hFFFC);
    check("rev_dir", {31'd0, dir}, 32'd0);
    step(2'b11, 1);
    @(negedge clock);
    check("err_early", {31'd0, err}, 32'd0);
    @(negedge clock);
    check("err_set", {31'd0, err}, 32'd1);
    check("err_pos_hold", {16'd0, position}, 32'hFFFC);
    check("err_dir_hold", {31'd0, dir}, 32'd0);
    settle();
    check("err_sticky", {31'd0, err}, 32'd1);
    @(negedge clock); clear = 1'b1;
    @(negedge clock); clear = 1'b0;
    m_pos = 16'h0;
    check("clr_pos", {16'd0, position}, 32'd0);
    check("clr_err", {31'd0, err}, 32'd0);
    step(nxt(m_prev), 3);
    settle();
    check("post_clr_pos", {16'd0, position}, 32'd1);
    while (m_pos != 16'h7FFF) step(nxt(m_prev), 1);
    settle();
    check("near_wrap_pos", {16'd0, position}, 32'h7FFF);
    step(nxt(m_prev), 3);
    settle();
    check("wrap_pos", {16'd0, position}, 32'h8000);
    @(negedge clock);
    {a, b} = nxt(m_prev);
    m_prev = nxt(m_prev);
    x.fwd = 1'b1; x.pos = 16'h0; x.cyc = cyc + 2; q.push_back(x);
    @(negedge clock); clear = 1'b1;
    @(negedge clock); clear = 1'b0;
    m_pos = 16'h0;
    check("clr_fwd_pos", {16'd0, position}, 32'd0);
    settle();
    for (int k = 0; k < 6; k++) step(nxt(m_prev), 2);
    step(m_prev == 2'b00 ? 2'b01 : m_prev == 2'b01 ? 2'b11 : m_prev == 2'b11 ? 2'b10 : 2'b00, 2);
    settle();
    check("pre_rst_pos", {16'd0, position}, 32'd5);
    check("pre_rst_dir", {31'd0, dir}, 32'd0);
    @(negedge clock);
    #2 reset = 1'b0;
    {a, b} = 2'b10;
    #1;
    check("async_pos", {16'd0, position}, 32'd0);
    check("async_flags", {28'd0, up, dn, dir, err}, 32'b0010);
    @(negedge clock);
    reset = 1'b1;
    m_prev = 2'b10;
    m_pos = 16'h0;
    repeat (10) @(negedge clock);
    check("rerst_pos", {16'd0, position}, 32'd0);
    step(2'b11, 3);
    settle();
    check("rerst_step_pos", {16'd0, position}, 32'd1);
    check("sb_empty", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/quad_decoder.md
# quad_decoder

Quadrature decoder that consumes the two debounced encoder channels (A and B, each the output of a debounce filter instance) and produces a x4-resolution signed position count, per-edge step pulses, a direction flag and a sticky illegal-transition flag. It sits directly downstream of the debounce filters and upstream of whatever reads position. Inputs are already synchronous to `clock` because they come from filter outputs, so no synchronizer is included.

## Interface
- `CNT_WIDTH`, default 16: width of the position counter, two's complement.
- `clock`  input  1  system clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `a`  input  1  debounced channel A.
- `b`  input  1  debounced channel B.
- `clear`  input  1  synchronous clear of `position` and `err`.
- `position`  output  CNT_WIDTH  signed edge count; +1 per forward edge, -1 per reverse edge.
- `up`  output  1  one-cycle pulse per forward edge.
- `dn`  output  1  one-cycle pulse per reverse edge.
- `dir`  output  1  direction of the last valid step; 1 = forward.
- `err`  output  1  sticky flag, set on an illegal transition.

## Operation
- Internal registers:
  - `cur` (2 bits) holds {a,b} sampled each edge.
  - `prev` (2 bits) holds the previous `cur`.
  - `primed` (1 bit) marks that `cur`/`prev` hold real samples.
- Reset (asynchronous, `reset`=0): `cur`=00, `prev`=00, `primed`=0, `position`=0, `up`=0, `dn`=0, `dir`=1, `err`=0.
- Priming:
  - First edge after reset release loads both `cur` and `prev` with {a,b} and sets `primed`=1.
  - No decode occurs on this edge, so a static input level at reset release never produces a step or an error.
- Decode uses state {prev} -> {cur}. It is evaluated every edge while `primed`=1, and all outputs are registered.
- Forward (A leads B) sequence: 00→10→11→01→00. Each such transition is a forward edge.
  - `up`=1 for one cycle, `position`+=1, `dir`=1.
- Reverse sequence: 00→01→11→10→00. Each such transition is a reverse edge.
  - `dn`=1 for one cycle, `position`-=1, `dir`=0.
- No change (`prev`==`cur`): `up`=`dn`=0; `position` and `dir` hold.
- Illegal transition (both bits differ: 00↔11, 01↔10):
  - `err` is set to 1 and stays set.
  - `up`=`dn`=0; `position` and `dir` hold.
- `up` and `dn` are never high in the same cycle.
- Arithmetic: `position` wraps modulo 2^CNT_WIDTH.
  - With CNT_WIDTH=16: 0x7FFF +1 → 0x8000, and 0x0000 -1 → 0xFFFF.
  - There is no saturation.
- `clear`=1:
  - Next edge: `position`=0, `err`=0.
  - It overrides any increment or decrement, and an illegal transition in the same cycle.
  - `up`, `dn` and `dir` still reflect that cycle's decode.
  - `cur`/`prev` sampling is unaffected.
- Reset mid-operation: asynchronous return to the reset values above, and priming repeats.

## Timing
- Input change latency, with a/b changing before rising edge k:
  - Edge k: `cur` captures the new value.
  - Edge k+1: `prev` captures it, and `up`/`dn`, `position`, `dir` and `err` update.
- Step pulse width: exactly one clock.
- Maximum step rate: one edge per clock. Consecutive edges on consecutive clocks each produce a pulse and a count.
- `clear` latency: one clock. `position` reads 0 after the edge that samples `clear`=1.
- After reset release, the first decode-capable edge is the second rising edge. Input changes before the first edge are absorbed by priming.

## Test plan
- Reset hold, then release with a=1, b=1 held for 10 cycles → `position`=0, `up`=`dn`=0, `err`=0, `dir`=1 throughout.
- Forward: from 00, drive 10,11,01,00 each held 5 cycles, repeated 3 times → 12 `up` pulses, each one cycle wide, 2 cycles after its input change. `position`=12, `dir`=1, `dn` never asserted.
- Reverse: from `position`=12 and a=b=0, drive 01,11,10,00 four times → 16 `dn` pulses. `position`=-4 (0xFFFC), `dir`=0.
- Illegal, then clear:
  - From 00, jump to 11 → `err`=1 two cycles later; `position` and `dir` unchanged.
  - Then pulse `clear` for 1 cycle → `err`=0, `position`=0.
  - Then a forward edge → `position`=1.
- Wrap and simultaneous clear:
  - Preload by stepping to 0x7FFF (or use CNT_WIDTH=4 and step to 7), then one forward edge → 0x8000 (or 0x8).
  - Forward edge coincident with `clear` → `position`=0 and `up`=1.
- Async reset mid-run: assert `reset`=0 between clock edges at `position`=5 → all outputs return to reset values immediately, without a clock edge. After release with inputs at 10, there is no pulse until the next input change.
